round_sequencer: RTL and testbench

Game-level controller for the memory-pattern game. After level selection it sequences pattern generation, LED playback and button capture for each round, compares captured input against the pattern, keeps score, inserts an inter-round gap and a capture timeout, and ends the game after a fixed number of rounds. It sits in `GameManager` between `level_select` and the `pattern_generator` / `print_pattern` / `input_trim` chain, replacing ad-hoc enable chaining.

---
 rtl/round_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_round_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// round_sequencer: game-level controller for the memory-pattern game.
// Runs each round in order: pattern generation, LED playback and button
// capture. It then compares the captured entries against the pattern, keeps
// the score, waits out an inter-round gap and stops after NUM_ROUNDS rounds.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tick                     one-clk strobe from the slow timebase
//   start, level[2:0]        level-select end pulse and one-hot level
//   gen_en / gen_done        pattern generator handshake
//   print_en / print_done    LED playback handshake
//   input_en / input_done    button capture handshake
//   pattern, trimmed [47:0]  16 x 3-bit entries, entry i at [3i+2:3i]
//   sub_rst                  one-cycle submodule clear after each round
//   round_num, score         completed rounds, fully correct rounds
//   match_cnt                matching entries in the last checked round
//   round_ok, timeout        round fully correct pulse / last capture timed out
//   lvl_err                  pulse on start with an invalid level
//   busy, game_over          game in progress / game finished
module round_sequencer #(
  parameter int NUM_ROUNDS    = 10,
  parameter int GAP_TICKS     = 4,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic [2:0]  level,
  output logic        gen_en,
  input  logic        gen_done,
  output logic        print_en,
  input  logic        print_done,
  output logic        input_en,
  input  logic        input_done,
  input  logic [47:0] pattern,
  input  logic [47:0] trimmed,
  output logic        sub_rst,
  output logic [3:0]  round_num,
  output logic [3:0]  score,
  output logic [4:0]  match_cnt,
  output logic        round_ok,
  output logic        timeout,
  output logic        lvl_err,
  output logic        busy,
  output logic        game_over
);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_PRINT, S_INPUT, S_CHECK, S_GAP, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    n_q, n_d;          // entries per round: 4, 8 or 16
  logic [3:0]    round_q, round_d;
  logic [3:0]    score_q, score_d;
  logic [4:0]    match_q, match_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          sub_rst_q, sub_rst_d;
  logic          round_ok_q, round_ok_d;
  logic          lvl_err_q, lvl_err_d;

  logic          lvl_ok;
  logic [4:0]    lvl_n;
  logic          tmo_hit, gap_hit;
  logic [15:0]   eq;
  logic [4:0]    hits, match_now;

  assign lvl_ok  = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);
  assign lvl_n   = (level == 3'b001) ? 5'd4 : (level == 3'b010) ? 5'd8 : 5'd16;
  // A done input takes priority over a coincident tick, so these terminal
  // conditions are only acted on when the matching done is low.
  assign tmo_hit = tick && (tcnt_q == TW'(TIMEOUT_TICKS - 1));
  assign gap_hit = tick && (gcnt_q == GW'(GAP_TICKS - 1));

  // Per-entry compare; entries at or above N are masked out.
  for (genvar i = 0; i < 16; i++) begin : g_cmp
    assign eq[i] = (pattern[3*i +: 3] == trimmed[3*i +: 3]) && (5'(i) < n_q);
  end

  always_comb begin
    hits = '0;
    for (int i = 0; i < 16; i++) hits = hits + 5'(eq[i]);
  end

  // A timed-out capture scores zero regardless of what was captured.
  assign match_now = timeout_q ? 5'd0 : hits;

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      round_q    <= '0;
      score_q    <= '0;
      match_q    <= '0;
      timeout_q  <= 1'b0;
      tcnt_q     <= '0;
      gcnt_q     <= '0;
      sub_rst_q  <= 1'b0;
      round_ok_q <= 1'b0;
      lvl_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      round_q    <= round_d;
      score_q    <= score_d;
      match_q    <= match_d;
      timeout_q  <= timeout_d;
      tcnt_q     <= tcnt_d;
      gcnt_q     <= gcnt_d;
      sub_rst_q  <= sub_rst_d;
      round_ok_q <= round_ok_d;
      lvl_err_q  <= lvl_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start && lvl_ok) state_d = S_GEN;
      S_GEN:          if (gen_done)        state_d = S_PRINT;
      S_PRINT:        if (print_done)      state_d = S_INPUT;
      S_INPUT:        if (input_done || tmo_hit) state_d = S_CHECK;
      S_CHECK:        state_d = S_GAP;
      S_GAP:          if (gap_hit)
                        state_d = (round_q == 4'(NUM_ROUNDS)) ? S_DONE : S_GEN;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    n_d        = n_q;
    round_d    = round_q;
    score_d    = score_q;
    match_d    = match_q;
    timeout_d  = timeout_q;
    tcnt_d     = tcnt_q;
    gcnt_d     = gcnt_q;
    sub_rst_d  = 1'b0;
    round_ok_d = 1'b0;
    lvl_err_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (lvl_ok) begin
            n_d       = lvl_n;
            round_d   = '0;
            score_d   = '0;
            match_d   = '0;
            timeout_d = 1'b0;
          end else begin
            lvl_err_d = 1'b1;
          end
        end
      end
      S_PRINT: if (print_done) tcnt_d = '0;
      S_INPUT: begin
        if (input_done)   timeout_d = 1'b0;
        else if (tmo_hit) timeout_d = 1'b1;
        else if (tick)    tcnt_d    = tcnt_q + 1'b1;
      end
      S_CHECK: begin
        match_d   = match_now;
        round_d   = round_q + 1'b1;
        sub_rst_d = 1'b1;
        gcnt_d    = '0;
        if (match_now == n_q) begin
          score_d    = score_q + 1'b1;
          round_ok_d = 1'b1;
        end
      end
      S_GAP: if (tick && !gap_hit) gcnt_d = gcnt_q + 1'b1;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    gen_en    = (state_q == S_GEN);
    print_en  = (state_q == S_PRINT);
    input_en  = (state_q == S_INPUT);
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    game_over = (state_q == S_DONE);
    sub_rst   = sub_rst_q;
    round_ok  = round_ok_q;
    lvl_err   = lvl_err_q;
    round_num = round_q;
    score     = score_q;
    match_cnt = match_q;
    timeout   = timeout_q;
  end
endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;
  localparam int NR = 10;
  localparam int GP = 4;
  localparam int TO = 40;

  logic        clk, rst, tick, start;
  logic [2:0]  level;
  logic        gen_en, gen_done, print_en, print_done, input_en, input_done;
  logic [47:0] pattern, trimmed;
  logic        sub_rst, round_ok, timeout, lvl_err, busy, game_over;
  logic [3:0]  round_num, score;
  logic [4:0]  match_cnt;

  round_sequencer #(.NUM_ROUNDS(NR), .GAP_TICKS(GP), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .level(level),
    .gen_en(gen_en), .gen_done(gen_done), .print_en(print_en),
    .print_done(print_done), .input_en(input_en), .input_done(input_done),
    .pattern(pattern), .trimmed(trimmed), .sub_rst(sub_rst),
    .round_num(round_num), .score(score), .match_cnt(match_cnt),
    .round_ok(round_ok), .timeout(timeout), .lvl_err(lvl_err),
    .busy(busy), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rnd;
    logic [3:0] sc;
    logic [4:0] mc;
    logic       ok;
    logic       to;
  } exp_t;

  exp_t sb[$];
  exp_t mexp, mact;
  int   checks = 0, errors = 0;
  int   ok_cnt = 0, sr_cnt = 0, lerr_cnt = 0;
  int   exp_round, exp_score;
  logic [4:0] cur_n;

  function automatic logic [21:0] outs();
    return {gen_en, print_en, input_en, sub_rst, round_num, score, match_cnt,
            round_ok, timeout, lvl_err, busy, game_over};
  endfunction

  function automatic logic sel(input int w);
    case (w)
      0: return gen_en;
      1: return print_en;
      2: return input_en;
      default: return sub_rst;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_sig(input int w, input string nm);
    int n = 0;
    while (!sel(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!sel(w)) begin
      errors++;
      $display("FAIL wait_%s: got 0 want 1 within 200 cycles", nm);
    end
  endtask

  // Scoreboard monitor: one expected entry per completed round.
  always @(negedge clk) begin
    if (!rst) begin
      if (round_ok) ok_cnt++;
      if (sub_rst)  sr_cnt++;
      if (lvl_err)  lerr_cnt++;
      if (sub_rst) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got sub_rst with empty queue want none");
        end else begin
          mexp = sb.pop_front();
          mact = {round_num, score, match_cnt, round_ok, timeout};
          if (mact !== mexp) begin
            errors++;
            $display("FAIL round_result: got rnd=%0d sc=%0d mc=%0d ok=%0b to=%0b want rnd=%0d sc=%0d mc=%0d ok=%0b to=%0b",
                     mact.rnd, mact.sc, mact.mc, mact.ok, mact.to,
                     mexp.rnd, mexp.sc, mexp.mc, mexp.ok, mexp.to);
          end
        end
      end
    end
  end

  // mode 0: input_done; 1: timeout; 2: input_done on the final timeout tick
  task automatic do_round(input logic [47:0] pat, input logic [47:0] trm,
                          input int mode, input logic [4:0] em);
    exp_t e;
    pattern = pat;
    trimmed = trm;
    wait_sig(0, "gen_en");
    repeat (2) @(negedge clk);
    gen_done = 1'b1; @(negedge clk); gen_done = 1'b0;
    wait_sig(1, "print_en");
    repeat (2) @(negedge clk);
    print_done = 1'b1; @(negedge clk); print_done = 1'b0;
    wait_sig(2, "input_en");
    exp_round++;
    if (em == cur_n) exp_score++;
    e.rnd = 4'(exp_round);
    e.sc  = 4'(exp_score);
    e.mc  = em;
    e.ok  = (em == cur_n);
    e.to  = (mode == 1);
    sb.push_back(e);
    case (mode)
      0: begin
        repeat (2) @(negedge clk);
        input_done = 1'b1; @(negedge clk); input_done = 1'b0;
      end
      1: repeat (TO) begin
        tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
      end
      default: begin
        repeat (TO - 1) begin
          tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
        end
        tick = 1'b1; input_done = 1'b1; @(negedge clk);
        tick = 1'b0; input_done = 1'b0;
      end
    endcase
    wait_sig(3, "sub_rst");
    repeat (GP) begin
      tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
    end
  endtask

  task automatic start_game(input logic [2:0] lv, input logic [4:0] n);
    level = lv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur_n = n; exp_round = 0; exp_score = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; level = 3'b000;
    gen_done = 1'b0; print_done = 1'b0; input_done = 1'b0;
    pattern = '0; trimmed = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(outs()), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", 32'(outs()), 0);

    // Invalid level
    level = 3'b011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lvl_err_pulse", lvl_err, 1);
    chk("lvl_err_busy", busy, 0);
    chk("lvl_err_gen_en", gen_en, 0);
    @(negedge clk);
    chk("lvl_err_cleared", lvl_err, 0);
    chk("lvl_err_gen_en2", gen_en, 0);

    // L1, 10 perfect rounds
    start_game(3'b001, 5'd4);
    chk("l1_gen_en", gen_en, 1);
    for (int r = 0; r < NR; r++) do_round(48'h0123456789AB, 48'h0123456789AB, 0, 5'd4);
    chk("l1_score", score, 10);
    chk("l1_round_num", round_num, 10);
    chk("l1_game_over", game_over, 1);
    chk("l1_busy", busy, 0);
    chk("l1_round_ok_count", ok_cnt, 10);
    chk("l1_sub_rst_count", sr_cnt, 10);

    // Restart from DONE with L3
    start_game(3'b100, 5'd16);
    chk("l3_gen_en", gen_en, 1);
    chk("l3_round_clr", round_num, 0);
    chk("l3_score_clr", score, 0);
    chk("l3_match_clr", match_cnt, 0);
    chk("l3_game_over", game_over, 0);
    do_round(48'h123456789ABC, 48'h123456789ABC ^ 48'h200000000000, 0, 5'd15);
    do_round(48'h123456789ABC, 48'h123456789ABC, 0, 5'd16);
    do_round(48'h123456789ABC, 48'h123456789ABC, 1, 5'd0);
    do_round(48'h123456789ABC, 48'h123456789ABC, 2, 5'd16);

    // start during PRINT is ignored
    wait_sig(0, "gen_en");
    gen_done = 1'b1; @(negedge clk); gen_done = 1'b0;
    wait_sig(1, "print_en");
    level = 3'b001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("print_start_print_en", print_en, 1);
    chk("print_start_gen_en", gen_en, 0);
    chk("print_start_round", round_num, 4);
    print_done = 1'b1; @(negedge clk); print_done = 1'b0;
    wait_sig(2, "input_en");

    // Asynchronous reset mid-INPUT
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", 32'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_game(3'b010, 5'd8);
    chk("l2_gen_en", gen_en, 1);
    do_round(48'h0123456789AB, 48'h0123456789AB ^ 48'hFFFFFF200000, 0, 5'd7);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_game(3'b001, 5'd4);
    do_round(48'h0123456789AB, 48'h0123456789AB ^ 48'hFFFFFFFFF000, 0, 5'd4);
    chk("l1b_score", score, 1);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("lvl_err_count", lerr_cnt, 1);
    chk("round_ok_total", ok_cnt, 13);
    chk("sub_rst_total", sr_cnt, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
